writeback_module: RTL and testbench
===================================

Name: writeback_module

Overview:
- Final pipeline stage and the writer for both register files that decode_module reads.
- Takes the execute/memory-stage result and produces the register-file write bundle that decode consumes as ResRV2, R_V_dest3, VF3 and Wreg3.
- Memory returns 32-bit beats, so this block assembles loads into full registers: a vector load needs LANES beats, a scalar load needs one.
- While a load is assembling, it stalls the front of the pipe and publishes the pending destination for hazard checks.

Parameters:
LANES, 4, 32-bit beats per vector register
LANE_W, 32, beat / scalar width in bits
AW, 4, register address width

Ports:
clk  input  1  pipeline clock
rst_n  input  1  asynchronous active-low reset
valid_in  input  1  result bundle from previous stage is valid
vf_in  input  1  destination is the vector file (1) or the scalar file (0)
wreg_in  input  1  instruction writes a register
rmem_in  input  1  result comes from memory (load)
dest_in  input  AW  destination register index
alu_res  input  LANES*LANE_W  ALU/vector-unit result
mem_rdata  input  LANE_W  memory read beat
mem_rvalid  input  1  mem_rdata valid this cycle
wb_data  output  LANES*LANE_W  write data (drives ResRV2)
wb_dest  output  AW  write index (drives R_V_dest3)
wb_vf  output  1  vector-file select (drives VF3)
wb_wreg  output  1  one-cycle write strobe (drives Wreg3)
stall  output  1  hold upstream stages
busy_dest  output  AW  destination of the load in progress
busy_vf  output  1  file select of the load in progress

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs are 0, state is IDLE, beat counter and assembly buffer are 0.
- States are IDLE and COLLECT. stall = (state==COLLECT), registered.
- IDLE, valid_in=1, rmem_in=0 (ALU result):
  - Next edge: wb_data=alu_res, wb_dest=dest_in, wb_vf=vf_in, wb_wreg=wreg_in.
  - Latency is 1 cycle. Back-to-back results are accepted every cycle.
- IDLE, valid_in=1, rmem_in=1 (load):
  - Latch dest_in and vf_in into busy_dest and busy_vf; target = vf_in ? LANES : 1; go to COLLECT.
  - wb_wreg=0 on that edge.
- COLLECT:
  - Each cycle with mem_rvalid=1 stores mem_rdata into lane cnt (lane 0 = bits[31:0], ascending), then cnt++.
  - Cycles with mem_rvalid=0 hold state; there is no timeout.
  - On the edge that stores the final beat (cnt==target-1): wb_data = assembled buffer including that beat; wb_dest=busy_dest; wb_vf=busy_vf; wb_wreg=wreg latched at accept.
  - On that same edge: return to IDLE, stall drops, busy_* clear to 0, cnt clears.
  - Scalar loads zero-extend: wb_data[127:32]=0.
- wb_wreg is a single-cycle pulse. With no new write it returns to 0 the next cycle. wb_data and wb_dest hold their last value.
- valid_in=0 in IDLE, or wreg_in=0: wb_wreg=0 next cycle. A load with wreg_in=0 still consumes its beats.
- valid_in is ignored in COLLECT; upstream holds its bundle because stall=1. The held bundle is accepted on the first IDLE cycle.
- mem_rvalid is ignored in IDLE.
- Destination index 0 is passed through unmodified; the register files own any R0 policy.
- Reset asserted mid-COLLECT discards partial data. No write is emitted and stall clears immediately.

Decomposition:
- Shared package pipe_pkg: LANES, LANE_W, AW constants; typedef wb_bundle_t {data, dest, vf, wreg}; enum wb_state_t {IDLE, COLLECT}.
- One sub-module: beat_assembler holds the lane buffer, beat counter and done flag. The FSM and output register stay in writeback_module.

Test Plan:
- Reset, then ALU result alu_res=128'h1, dest=3, vf=0, wreg=1 -> next cycle wb_wreg=1, wb_dest=3, wb_data=1; the following cycle wb_wreg=0.
- Vector load dest=5 with beats 11,22,33,44 on consecutive cycles -> stall high for 4 cycles, busy_dest=5, busy_vf=1; then one wb_wreg pulse with wb_data=128'h00000044_00000033_00000022_00000011 and wb_vf=1.
- Vector load with mem_rvalid gaps (beat, 2 idle, beat, beat, 1 idle, beat) -> write occurs exactly on the 4th beat edge; stall stays continuously high until then.
- Scalar load dest=2, beat 32'hDEADBEEF -> 1-cycle stall, wb_data=128'h0...DEADBEEF, wb_vf=0.
- ALU result presented while a vector load is collecting -> not accepted until stall drops; it appears as a write one cycle after the load's write.
- rst_n pulsed low after 2 of 4 beats -> all outputs 0 asynchronously, no wb_wreg pulse; a subsequent fresh load assembles correctly from lane 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared widths, write-bundle layout and FSM encoding for the writeback stage.
// The write bundle is what decode sees as ResRV2 / R_V_dest3 / VF3 / Wreg3.
// CW sizes the beat counter so it can index every lane of a vector register.
package pipe_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 32;
    localparam int AW     = 4;
    localparam int DW     = LANES * LANE_W;
    localparam int CW     = (LANES > 1) ? $clog2(LANES) : 1;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] dest;
        logic          vf;
        logic          wreg;
    } wb_bundle_t;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } wb_state_t;

endpackage

// File: rtl/writeback_module_beat_assembler.sv
// Assembles 32-bit memory beats into a register-wide value, lane 0 first.
// Latency: done and asm_data are combinational on the beat that completes the load.
// Backpressure: none; beats are taken whenever beat_vld is high.
// Ports: start/start_vf arm a new load (vector needs LANES beats, scalar one);
//        beat_vld/beat_dat feed beats; asm_data is the buffer with the current
//        beat merged in; done flags the final beat.
module beat_assembler
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              start_vf,
    input  logic              beat_vld,
    input  logic [LANE_W-1:0] beat_dat,
    output logic [DW-1:0]     asm_data,
    output logic              done
);

    logic [DW-1:0] lane_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] last_q;

    // Merge the incoming beat into its lane so the completing beat can be
    // written back on the same edge it arrives.
    always_comb begin
        asm_data = lane_q;
        for (int l = 0; l < LANES; l++) begin
            if (CW'(l) == cnt_q) begin
                asm_data[l*LANE_W +: LANE_W] = beat_dat;
            end
        end
        done = beat_vld && (cnt_q == last_q);
    end

    // The buffer is zeroed on completion so a following scalar load comes
    // out zero-extended without extra masking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= '0;
            cnt_q  <= '0;
            last_q <= '0;
        end else if (start) begin
            lane_q <= '0;
            cnt_q  <= '0;
            last_q <= start_vf ? CW'(LANES - 1) : '0;
        end else if (done) begin
            lane_q <= '0;
            cnt_q  <= '0;
        end else if (beat_vld) begin
            lane_q <= asm_data;
            cnt_q  <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/writeback_module.sv
// Final pipeline stage: registers ALU results and assembled loads into the regfile write bundle.
// Latency: ALU result 1 cycle; load writes on the edge that stores its last beat.
// Backpressure: stall is high for the whole load collection; valid_in is ignored meanwhile.
// Ports: valid_in/vf_in/wreg_in/rmem_in/dest_in/alu_res = incoming result bundle;
//        mem_rdata/mem_rvalid = load beats; wb_* = write bundle (wb_wreg is a
//        one-cycle strobe); stall/busy_dest/busy_vf = hazard info for the front end.
module writeback_module
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic              vf_in,
    input  logic              wreg_in,
    input  logic              rmem_in,
    input  logic [AW-1:0]     dest_in,
    input  logic [DW-1:0]     alu_res,
    input  logic [LANE_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic [DW-1:0]     wb_data,
    output logic [AW-1:0]     wb_dest,
    output logic              wb_vf,
    output logic              wb_wreg,
    output logic              stall,
    output logic [AW-1:0]     busy_dest,
    output logic              busy_vf
);

    wb_state_t     state_q, state_d;
    wb_bundle_t    wb_q, wb_d;
    logic [AW-1:0] busy_dest_q, busy_dest_d;
    logic          busy_vf_q, busy_vf_d;
    logic          busy_wreg_q, busy_wreg_d;
    logic          load_acc;
    logic          beat_vld;
    logic          done;
    logic [DW-1:0] asm_data;

    // mem_rvalid only counts while a load is outstanding.
    assign beat_vld = (state_q == COLLECT) && mem_rvalid;

    beat_assembler u_asm (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (load_acc),
        .start_vf (vf_in),
        .beat_vld (beat_vld),
        .beat_dat (mem_rdata),
        .asm_data (asm_data),
        .done     (done)
    );

    always_comb begin
        state_d     = state_q;
        wb_d        = wb_q;
        wb_d.wreg   = 1'b0;          // strobe unless re-asserted below
        busy_dest_d = busy_dest_q;
        busy_vf_d   = busy_vf_q;
        busy_wreg_d = busy_wreg_q;
        load_acc    = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    if (rmem_in) begin
                        load_acc    = 1'b1;
                        busy_dest_d = dest_in;
                        busy_vf_d   = vf_in;
                        busy_wreg_d = wreg_in;
                        state_d     = COLLECT;
                    end else begin
                        wb_d = '{data: alu_res, dest: dest_in, vf: vf_in, wreg: wreg_in};
                    end
                end
            end
            COLLECT: begin
                if (done) begin
                    wb_d = '{data: asm_data, dest: busy_dest_q, vf: busy_vf_q, wreg: busy_wreg_q};
                    busy_dest_d = '0;
                    busy_vf_d   = 1'b0;
                    busy_wreg_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wb_q        <= '0;
            busy_dest_q <= '0;
            busy_vf_q   <= 1'b0;
            busy_wreg_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wb_q        <= wb_d;
            busy_dest_q <= busy_dest_d;
            busy_vf_q   <= busy_vf_d;
            busy_wreg_q <= busy_wreg_d;
        end
    end

    assign wb_data   = wb_q.data;
    assign wb_dest   = wb_q.dest;
    assign wb_vf     = wb_q.vf;
    assign wb_wreg   = wb_q.wreg;
    assign stall     = (state_q == COLLECT);
    assign busy_dest = busy_dest_q;
    assign busy_vf   = busy_vf_q;

endmodule

// File: tb/tb_writeback_module.sv
module tb_writeback_module;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid_in, vf_in, wreg_in, rmem_in, mem_rvalid;
    logic [3:0]   dest_in;
    logic [127:0] alu_res;
    logic [31:0]  mem_rdata;
    logic [127:0] wb_data;
    logic [3:0]   wb_dest, busy_dest;
    logic         wb_vf, wb_wreg, stall, busy_vf;

    typedef struct packed {
        logic [127:0] data;
        logic [3:0]   dest;
        logic         vf;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    writeback_module dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .vf_in(vf_in),
        .wreg_in(wreg_in), .rmem_in(rmem_in), .dest_in(dest_in),
        .alu_res(alu_res), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .wb_data(wb_data), .wb_dest(wb_dest), .wb_vf(wb_vf), .wb_wreg(wb_wreg),
        .stall(stall), .busy_dest(busy_dest), .busy_vf(busy_vf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wb_wreg === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 1'b1, 1'b0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_data", wb_data, e.data);
                chk("sb_dest", {124'd0, wb_dest}, {124'd0, e.dest});
                chk("sb_vf", wb_vf, e.vf);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        valid_in   = 1'b0;
        rmem_in    = 1'b0;
        mem_rvalid = 1'b0;
        repeat (n) step();
    endtask

    task automatic alu(input logic [127:0] d, input logic [3:0] dst, input logic vf, input logic wr);
        valid_in = 1'b1; rmem_in = 1'b0; alu_res = d; dest_in = dst; vf_in = vf; wreg_in = wr;
        if (wr) exp_q.push_back('{data: d, dest: dst, vf: vf});
        step();
    endtask

    // Issue a load, then feed its beats; gaps holds 4 idle-cycle counts (one nibble per beat).
    // with_alu keeps an ALU result presented upstream while the load collects.
    task automatic do_load(input logic [3:0] dst, input logic vf, input logic wr,
                           input logic [127:0] beats, input logic [15:0] gaps, input bit with_alu);
        int n;
        logic [127:0] exp_d;
        n = vf ? 4 : 1;
        exp_d = '0;
        for (int i = 0; i < n; i++) exp_d[i*32 +: 32] = beats[i*32 +: 32];
        if (wr) exp_q.push_back('{data: exp_d, dest: dst, vf: vf});
        valid_in = 1'b1; rmem_in = 1'b1; dest_in = dst; vf_in = vf; wreg_in = wr; mem_rvalid = 1'b0;
        step();
        valid_in = 1'b0; rmem_in = 1'b0;
        if (with_alu) begin
            valid_in = 1'b1; alu_res = 128'hA5A5; dest_in = 4'd7; vf_in = 1'b0; wreg_in = 1'b1;
            exp_q.push_back('{data: 128'hA5A5, dest: 4'd7, vf: 1'b0});
        end
        chk("accept_no_wreg", wb_wreg, 1'b0);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < int'(gaps[i*4 +: 4]); g++) begin
                mem_rvalid = 1'b0;
                chk("gap_stall", stall, 1'b1);
                step();
            end
            mem_rvalid = 1'b1;
            mem_rdata  = beats[i*32 +: 32];
            chk("collect_stall", stall, 1'b1);
            chk("collect_busy_dest", {124'd0, busy_dest}, {124'd0, dst});
            chk("collect_busy_vf", busy_vf, vf);
            chk("collect_no_wreg", wb_wreg, 1'b0);
            step();
        end
        mem_rvalid = 1'b0;
        chk("done_stall", stall, 1'b0);
        chk("done_busy_dest", {124'd0, busy_dest}, 128'd0);
        chk("done_wreg", wb_wreg, wr);
        if (with_alu) begin
            step();
            chk("held_alu_wreg", wb_wreg, 1'b1);
            chk("held_alu_dest", {124'd0, wb_dest}, 128'd7);
            valid_in = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; valid_in = 1'b0; vf_in = 1'b0; wreg_in = 1'b0; rmem_in = 1'b0;
        dest_in = '0; alu_res = '0; mem_rdata = '0; mem_rvalid = 1'b0;
        #12;
        chk("rst_wb_data", wb_data, 128'd0);
        chk("rst_wb_wreg", wb_wreg, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_busy_dest", {124'd0, busy_dest}, 128'd0);
        rst_n = 1'b1;
        step();

        // ALU result: 1-cycle latency, single-cycle strobe, data holds.
        alu(128'h1, 4'd3, 1'b0, 1'b1);
        chk("alu_wreg", wb_wreg, 1'b1);
        chk("alu_dest", {124'd0, wb_dest}, 128'd3);
        chk("alu_data", wb_data, 128'h1);
        idle(1);
        chk("alu_pulse_drop", wb_wreg, 1'b0);
        chk("alu_data_hold", wb_data, 128'h1);

        // Back-to-back ALU results, dest 0 passthrough, a non-writing result.
        alu(128'hCAFE_0000_1234, 4'd0, 1'b1, 1'b1);
        alu(128'h55, 4'd9, 1'b0, 1'b1);
        alu(128'h66, 4'd4, 1'b0, 1'b0);
        chk("nowreg_alu", wb_wreg, 1'b0);
        idle(1);

        // mem_rvalid in IDLE must not advance the assembler.
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
        step();
        chk("idle_rvalid_stall", stall, 1'b0);
        mem_rvalid = 1'b0;

        // Vector load, consecutive beats.
        do_load(4'd5, 1'b1, 1'b1, {32'h44, 32'h33, 32'h22, 32'h11}, 16'h0000, 1'b0);
        idle(1);
        // Vector load with gaps: beat, 2 idle, beat, beat, 1 idle, beat.
        do_load(4'd6, 1'b1, 1'b1, {32'hD4, 32'hC3, 32'hB2, 32'hA1}, 16'h1020, 1'b0);
        idle(1);
        // Scalar load directly after a vector one: upper lanes must be zero.
        do_load(4'd2, 1'b0, 1'b1, {96'd0, 32'hDEADBEEF}, 16'h0000, 1'b0);
        idle(1);
        // Load with no register write still consumes its beats.
        do_load(4'd8, 1'b1, 1'b0, {32'h4, 32'h3, 32'h2, 32'h1}, 16'h0100, 1'b0);
        idle(1);
        // ALU result held upstream while a vector load collects.
        do_load(4'd10, 1'b1, 1'b1, {32'h1004, 32'h1003, 32'h1002, 32'h1001}, 16'h0000, 1'b1);
        idle(1);

        // Reset after 2 of 4 beats: everything clears asynchronously, no write.
        valid_in = 1'b1; rmem_in = 1'b1; dest_in = 4'd9; vf_in = 1'b1; wreg_in = 1'b1;
        step();
        valid_in = 1'b0; rmem_in = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hEE01; step();
        mem_rdata = 32'hEE02; step();
        mem_rvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_stall", stall, 1'b0);
        chk("arst_busy_dest", {124'd0, busy_dest}, 128'd0);
        chk("arst_busy_vf", busy_vf, 1'b0);
        chk("arst_wb_data", wb_data, 128'd0);
        chk("arst_wb_wreg", wb_wreg, 1'b0);
        #1;
        rst_n = 1'b1;
        step();
        chk("post_rst_wreg", wb_wreg, 1'b0);
        do_load(4'd11, 1'b1, 1'b1, {32'h7004, 32'h7003, 32'h7002, 32'h7001}, 16'h0000, 1'b0);
        idle(2);

        chk("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
